unidirectional_bus_arbiter: RTL and testbench

// Shared unidirectional bus driven by N_SRC sources under round-robin arbitration.

---
 rtl/unidirectional_bus_arbiter_if.sv | 24 ++
 rtl/unidirectional_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_unidirectional_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/unidirectional_bus_arbiter_if.sv
// Bus bundle for unidirectional_bus_arbiter.
//   req     : per-source request / beat qualifier (source side drives)
//   din     : packed source words, source k at din[k*W +: W]
//   last    : per-source final-beat flag
//   gnt     : one-hot registered grant (arbiter drives)
//   z       : registered shared bus word, may float when idle
//   z_valid : z carries a word accepted on the previous edge
//   busy    : arbiter is serving a burst
// Modports: master = source/testbench side, slave = arbiter side.
interface unidirectional_bus_arbiter_if #(
    parameter int W     = 4,
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]   req;
    logic [N_SRC*W-1:0] din;
    logic [N_SRC-1:0]   last;
    logic [N_SRC-1:0]   gnt;
    logic [W-1:0]       z;
    logic               z_valid;
    logic               busy;

    modport master (output req, din, last, input gnt, z, z_valid, busy);
    modport slave  (input req, din, last, output gnt, z, z_valid, busy);
endinterface

// File: rtl/unidirectional_bus_arbiter.sv
// Round-robin arbiter for a shared unidirectional bus.
// N_SRC sources request the bus; the winner receives a one-hot grant and
// streams beats (qualified by its req bit) onto the registered output z.
// A burst ends on last, on MAX_BURST accepted beats, or when req drops.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : unidirectional_bus_arbiter_if.slave (req/din/last in,
//         gnt/z/z_valid/busy out)
module unidirectional_bus_arbiter #(
    parameter int W         = 4,
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 4,
    parameter bit TRISTATE  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    unidirectional_bus_arbiter_if.slave   bus
);
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   gnt_q, gnt_d;
    logic [W-1:0]       z_reg_q, z_reg_d;
    logic               z_valid_q, z_valid_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               found;
    int                 sel_idx;
    int                 cand;
    logic [CNT_W-1:0]   cnt_inc;
    logic               burst_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            z_reg_q    <= '0;
            z_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            z_reg_q    <= z_reg_d;
            z_valid_q  <= z_valid_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        z_reg_d    = z_reg_q;
        z_valid_d  = 1'b0;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        beat_cnt_d = beat_cnt_q;
        found      = 1'b0;
        sel_idx    = 0;
        cand       = 0;
        cnt_inc    = beat_cnt_q + 1'b1;
        burst_end  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Rotating priority: first requester at or after ptr wins.
                for (int i = 0; i < N_SRC; i++) begin
                    cand = (int'(ptr_q) + i) % N_SRC;
                    if (!found && bus.req[cand]) begin
                        found   = 1'b1;
                        sel_idx = cand;
                    end
                end
                if (found) begin
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    gidx_d         = IDX_W'(sel_idx);
                    beat_cnt_d     = '0;
                    state_d        = BUSY;
                    busy_d         = 1'b1;
                end
            end
            BUSY: begin
                if (bus.req[gidx_q]) begin
                    z_reg_d    = bus.din[int'(gidx_q)*W +: W];
                    z_valid_d  = 1'b1;
                    beat_cnt_d = cnt_inc;
                    // last and the beat limit may coincide; either ends it once.
                    burst_end  = bus.last[gidx_q] || (cnt_inc == CNT_W'(MAX_BURST));
                end else begin
                    burst_end  = 1'b1;
                end
                if (burst_end) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = (gidx_q == IDX_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.z_valid = z_valid_q;
    assign bus.busy    = busy_q;
    assign bus.z       = (TRISTATE && !z_valid_q) ? {W{1'bz}} : z_reg_q;

endmodule

// File: tb/tb_unidirectional_bus_arbiter.sv
module tb_unidirectional_bus_arbiter;
    localparam int W = 4;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [W-1:0] zfloat;

    unidirectional_bus_arbiter_if #(.W(W), .N_SRC(N)) bus ();

    unidirectional_bus_arbiter #(
        .W(W), .N_SRC(N), .MAX_BURST(4), .TRISTATE(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output check: grant, valid, busy, and bus word (floating when invalid).
    task automatic chk_all(input string tag, input logic [N-1:0] g, input logic v,
                           input logic b, input logic [W-1:0] zw);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".zv"}, 32'(bus.z_valid), 32'(v));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        if (v) chk({tag, ".z"}, {28'd0, bus.z}, {28'd0, zw});
        else   chk({tag, ".zf"}, {28'd0, bus.z}, {28'd0, zfloat});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        zfloat      = 'z;
        rst         = 1'b1;
        bus.req     = '0;
        bus.din     = '0;
        bus.last    = '0;

        // Test 1: reset, then idle with no requests
        #2;
        chk_all("t1_rst", 4'b0000, 1'b0, 1'b0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("t1_idle", 4'b0000, 1'b0, 1'b0, 4'h0);
        end

        // Test 2: source 1, two beats, last on beat 2
        bus.req = 4'b0010;
        bus.din[1*W +: W] = 4'b0011;
        tick();
        chk_all("t2_gnt", 4'b0010, 1'b0, 1'b1, 4'h0);
        tick();
        chk_all("t2_b1", 4'b0010, 1'b1, 1'b1, 4'b0011);
        bus.din[1*W +: W] = 4'b1010;
        bus.last = 4'b0010;
        tick();
        chk_all("t2_b2", 4'b0000, 1'b1, 1'b0, 4'b1010);
        bus.req  = 4'b0000;
        bus.last = 4'b0000;
        tick();
        chk_all("t2_end", 4'b0000, 1'b0, 1'b0, 4'h0);

        // Test 3: all request, single-beat bursts, round-robin from source 0
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.din  = {4'h8, 4'h4, 4'h2, 4'h1};
        bus.last = 4'b1111;
        bus.req  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_all("t3_gnt", 4'(1 << k), 1'b0, 1'b1, 4'h0);
            tick();
            chk_all("t3_rel", 4'b0000, 1'b1, 1'b0, 4'(1 << k));
        end
        tick();
        chk_all("t3_wrap", 4'b0001, 1'b0, 1'b1, 4'h0);
        bus.req  = 4'b0000;
        bus.last = 4'b0000;
        tick();
        chk_all("t3_drop", 4'b0000, 1'b0, 1'b0, 4'h0);

        // Test 4: source 2 held, no last: forced release after 4 beats
        bus.req = 4'b0100;
        bus.din = '0;
        bus.din[2*W +: W] = 4'b1110;
        tick();
        chk_all("t4_gnt", 4'b0100, 1'b0, 1'b1, 4'h0);
        for (int b = 0; b < 3; b++) begin
            tick();
            chk_all("t4_beat", 4'b0100, 1'b1, 1'b1, 4'b1110);
        end
        tick();
        chk_all("t4_b4", 4'b0000, 1'b1, 1'b0, 4'b1110);
        tick();
        chk_all("t4_regnt", 4'b0100, 1'b0, 1'b1, 4'h0);
        bus.req = 4'b0000;
        tick();
        chk_all("t4_drop", 4'b0000, 1'b0, 1'b0, 4'h0);

        // Test 5: source 0 drops req after one beat; next search starts at 1
        bus.req = 4'b0001;
        bus.din[0*W +: W] = 4'b0101;
        tick();
        chk_all("t5_gnt", 4'b0001, 1'b0, 1'b1, 4'h0);
        tick();
        chk_all("t5_b1", 4'b0001, 1'b1, 1'b1, 4'b0101);
        bus.req = 4'b1010;
        tick();
        chk_all("t5_drop", 4'b0000, 1'b0, 1'b0, 4'h0);
        tick();
        chk_all("t5_next", 4'b0010, 1'b0, 1'b1, 4'h0);
        bus.req = 4'b0000;
        tick();
        chk_all("t5_end", 4'b0000, 1'b0, 1'b0, 4'h0);

        // Test 6: reset mid-burst of source 3
        bus.req = 4'b1000;
        bus.din[3*W +: W] = 4'b0111;
        tick();
        chk_all("t6_gnt", 4'b1000, 1'b0, 1'b1, 4'h0);
        tick();
        chk_all("t6_b1", 4'b1000, 1'b1, 1'b1, 4'b0111);
        rst = 1'b1;
        #1;
        chk_all("t6_rst", 4'b0000, 1'b0, 1'b0, 4'h0);
        bus.req = 4'b1001;
        tick();
        chk_all("t6_hold", 4'b0000, 1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        tick();
        chk_all("t6_src0", 4'b0001, 1'b0, 1'b1, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
